// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receiver with 16x oversampling that pairs consecutive
// good bytes (low byte first) into one word. A low byte left waiting too long
// in idle is dropped, so a lost high byte cannot shift the pairing for good.
module uart_word_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int NBITS_D = 16,
   parameter int TIMEOUT = 255
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx,
   input  logic               i_s_tick,
   output logic [DBIT-1:0]    o_dout,
   output logic               o_rx_done,
   output logic [NBITS_D-1:0] o_word,
   output logic               o_word_valid,
   output logic               o_frame_err
);

   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic               rx_meta_q;
   logic               rx_sync_q;
   state_t             state_q,      state_d;
   logic [3:0]         s_q,          s_d;
   logic [NW-1:0]      n_q,          n_d;
   logic [DBIT-1:0]    b_q,          b_d;
   logic [DBIT-1:0]    dout_q,       dout_d;
   logic               rx_done_q,    rx_done_d;
   logic [NBITS_D-1:0] word_q,       word_d;
   logic               word_valid_q, word_valid_d;
   logic               frame_err_q,  frame_err_d;
   logic [DBIT-1:0]    lo_q,         lo_d;
   logic               pending_q,    pending_d;
   logic [TW-1:0]      tmo_q,        tmo_d;

   // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Next-state logic: frame FSM, byte delivery, word pairing and the low-byte timeout.
   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      n_d          = n_q;
      b_d          = b_q;
      dout_d       = dout_q;
      rx_done_d    = 1'b0;
      word_d       = word_q;
      word_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      lo_d         = lo_q;
      pending_d    = pending_q;
      tmo_d        = tmo_q;

      case (state_q)
         IDLE: begin
            if (!rx_sync_q) begin
               state_d = START;
               s_d     = 4'd0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (i_s_tick) begin
               if (s_q == 4'd7) begin
                  if (rx_sync_q) begin
                     state_d = IDLE;          // glitch shorter than half a bit
                  end else begin
                     state_d = DATA;
                     s_d     = 4'd0;
                     n_d     = '0;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end else begin
               s_d = s_q;
            end
         end
         DATA: begin
            if (i_s_tick) begin
               if (s_q == 4'd15) begin
                  s_d = 4'd0;
                  b_d = {rx_sync_q, b_q[DBIT-1:1]};
                  if (n_q == NW'(DBIT - 1)) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + {{(NW-1){1'b0}}, 1'b1};
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end else begin
               s_d = s_q;
            end
         end
         STOP: begin
            if (i_s_tick) begin
               if (s_q == 4'(SB_TICK - 1)) begin
                  state_d = IDLE;
                  s_d     = 4'd0;
                  tmo_d   = '0;
                  if (rx_sync_q) begin
                     dout_d    = b_q;
                     rx_done_d = 1'b1;
                     if (pending_q) begin
                        word_d       = {b_q, lo_q};
                        word_valid_d = 1'b1;
                        pending_d    = 1'b0;
                     end else begin
                        lo_d      = b_q;
                        pending_d = 1'b1;
                     end
                  end else begin
                     frame_err_d = 1'b1;      // a bad frame also breaks the pairing
                     pending_d   = 1'b0;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end else begin
               s_d = s_q;
            end
         end
         default: begin
            state_d = IDLE;
            s_d     = 4'd0;
         end
      endcase

      // Idle ticks with a low byte waiting; a start edge on the same tick wins and freezes the count.
      if ((state_q == IDLE) && pending_q && i_s_tick && rx_sync_q) begin
         if (tmo_q == TW'(TIMEOUT - 1)) begin
            pending_d = 1'b0;
            tmo_d     = '0;
         end else begin
            tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
         end
      end else begin
         tmo_d = tmo_d;
      end
   end

   // State and registered outputs; reset drops any frame in progress silently.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= IDLE;
         s_q          <= 4'd0;
         n_q          <= '0;
         b_q          <= '0;
         dout_q       <= '0;
         rx_done_q    <= 1'b0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         lo_q         <= '0;
         pending_q    <= 1'b0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         n_q          <= n_d;
         b_q          <= b_d;
         dout_q       <= dout_d;
         rx_done_q    <= rx_done_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         frame_err_q  <= frame_err_d;
         lo_q         <= lo_d;
         pending_q    <= pending_d;
         tmo_q        <= tmo_d;
      end
   end

   assign o_dout       = dout_q;
   assign o_rx_done    = rx_done_q;
   assign o_word       = word_q;
   assign o_word_valid = word_valid_q;
   assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: serial frames driven bit by bit, every output pulse
// compared against an event list predicted by a byte-level pairing/timeout model.
module tb_uart_word_rx;

   localparam int TIMEOUT = 255;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_rx;
   logic        i_s_tick;
   logic [7:0]  o_dout;
   logic        o_rx_done;
   logic [15:0] o_word;
   logic        o_word_valid;
   logic        o_frame_err;

   int n_checks = 0;
   int n_fail   = 0;
   int div      = 1;
   int tick_cnt = 0;

   // expected pulse events: {rx_done, frame_err, word_valid, dout, word}
   logic [26:0] exp_q[$];
   bit          m_pend;
   logic [7:0]  m_lo;
   logic [7:0]  m_dout;
   logic [15:0] m_word;
   int          m_idle;

   uart_word_rx #(.DBIT(8), .SB_TICK(16), .NBITS_D(16), .TIMEOUT(TIMEOUT)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_rx         (i_rx),
      .i_s_tick     (i_s_tick),
      .o_dout       (o_dout),
      .o_rx_done    (o_rx_done),
      .o_word       (o_word),
      .o_word_valid (o_word_valid),
      .o_frame_err  (o_frame_err)
   );

   initial forever #5 i_clk = ~i_clk;

   // Oversampling tick: one pulse every div clocks.
   initial begin
      i_s_tick = 1'b0;
      forever begin
         @(posedge i_clk);
         #1;
         tick_cnt = tick_cnt + 1;
         if (tick_cnt >= div) tick_cnt = 0;
         i_s_tick = (tick_cnt == 0);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pulse monitor: every pulse cycle must match the next predicted event.
   initial begin : mon
      logic [26:0] obs;
      logic [26:0] e;
      forever begin
         @(negedge i_clk);
         if (o_rx_done || o_frame_err || o_word_valid) begin
            obs = {o_rx_done, o_frame_err, o_word_valid, o_dout, o_word};
            if (exp_q.size() == 0) begin
               check_eq("unexpected_pulse", 32'(obs), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq("pulse", 32'(obs), 32'(e));
            end
         end
      end
   end

   task automatic model_reset();
      exp_q.delete();
      m_pend = 1'b0;
      m_lo   = 8'h00;
      m_dout = 8'h00;
      m_word = 16'h0000;
      m_idle = 0;
   endtask

   // Byte-level behaviour: good bytes pair low-then-high, a bad stop breaks the pair.
   task automatic model_frame(input logic [7:0] b, input bit ok);
      bit wv;
      wv = 1'b0;
      if (ok) begin
         m_dout = b;
         if (m_pend) begin
            m_word = {b, m_lo};
            m_pend = 1'b0;
            wv     = 1'b1;
         end else begin
            m_lo   = b;
            m_pend = 1'b1;
            m_idle = 0;
         end
         exp_q.push_back({1'b1, 1'b0, wv, m_dout, m_word});
      end else begin
         m_pend = 1'b0;
         exp_q.push_back({1'b0, 1'b1, 1'b0, m_dout, m_word});
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(posedge i_clk); while (!i_s_tick);
      end
      #2;
   endtask

   task automatic idle(input int g);
      wait_ticks(g);
      m_idle = m_idle + g;
      if (m_pend && m_idle >= TIMEOUT) m_pend = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit ok);
      model_frame(b, ok);
      i_rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         i_rx = b[i];
         wait_ticks(16);
      end
      i_rx = ok;
      wait_ticks(16);
      i_rx = 1'b1;
      if (!ok) idle(20);
      check_eq("dout", 32'(o_dout), 32'(m_dout));
      check_eq("word", 32'(o_word), 32'(m_word));
      check_eq("events_seen", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      i_reset = 1'b0;
      i_rx    = 1'b1;
      model_reset();
      repeat (3) @(posedge i_clk);
      #1;
      check_eq("reset_dout", 32'(o_dout), 32'd0);
      check_eq("reset_word", 32'(o_word), 32'd0);
      check_eq("reset_pulses", 32'({o_rx_done, o_frame_err, o_word_valid}), 32'd0);
      #2 i_reset = 1'b1;

      // idle line: no pulses, outputs stay zero
      idle(1000);
      check_eq("idle_dout", 32'(o_dout), 32'd0);
      check_eq("idle_word", 32'(o_word), 32'd0);

      // single byte, no word
      send_frame(8'h5A, 1'b1);
      check_eq("dout_5a", 32'(o_dout), 32'h5A);

      // let 0x5A time out, then a back-to-back pair
      idle(300);
      send_frame(8'h34, 1'b1);
      send_frame(8'h12, 1'b1);
      check_eq("word_1234", 32'(o_word), 32'h1234);

      // short low glitch must be ignored
      i_rx = 1'b0;
      wait_ticks(3);
      i_rx = 1'b1;
      idle(40);

      // framing error keeps dout, then a fresh pair
      send_frame(8'hA5, 1'b0);
      check_eq("dout_kept", 32'(o_dout), 32'h12);
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      check_eq("word_0201", 32'(o_word), 32'h0201);

      // low byte timed out after TIMEOUT+1 idle ticks
      send_frame(8'h34, 1'b1);
      idle(TIMEOUT + 1);
      send_frame(8'h12, 1'b1);
      send_frame(8'h56, 1'b1);
      check_eq("word_5612", 32'(o_word), 32'h5612);

      // reset in the middle of a frame, with a low byte pending
      send_frame(8'h33, 1'b1);
      i_rx = 1'b0;
      wait_ticks(16);
      i_rx = 1'b1;
      wait_ticks(16);
      i_rx = 1'b0;
      wait_ticks(8);
      #1 i_reset = 1'b0;
      #1;
      check_eq("midrst_dout", 32'(o_dout), 32'd0);
      check_eq("midrst_word", 32'(o_word), 32'd0);
      check_eq("midrst_pulses", 32'({o_rx_done, o_frame_err, o_word_valid}), 32'd0);
      model_reset();
      i_rx = 1'b1;
      repeat (3) @(posedge i_clk);
      #3 i_reset = 1'b1;
      idle(30);
      send_frame(8'h77, 1'b1);

      // randomized traffic with a slower tick
      div = 3;
      idle(20);
      for (int k = 0; k < 30; k++) begin
         logic [7:0] rb;
         bit         rok;
         int         gap;
         rb  = 8'($urandom_range(0, 255));
         rok = ($urandom_range(0, 99) < 85);
         gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(300, 400))
                                           : int'($urandom_range(0, 150));
         idle(gap);
         send_frame(rb, rok);
      end

      idle(50);
      check_eq("drain", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
